// File: rtl/alu_arbiter.sv
// Two-port arbiter and sequencer for the shared single-cycle ALU, with an ID-tagged response bus.
// Latency: handshake in N, alu_en in N+1, alu_done expected in N+2, resp_valid in N+3. Next accept is in N+4 at the earliest.
// Backpressure: req_ready is high only in IDLE, so one operation is outstanding at a time. Responses cannot be stalled.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       per-port request handshake (bit i = port i)
//   req{0,1}_op/_a/_b         opcode and operands, latched on handshake
//   resp_*                    one-cycle response strobe plus persistent captured data
//   busy                      controller is not in IDLE
//   alu_en/control/srcA/srcB  drive to the ALU (one-cycle enable pulse)
//   alu_result/hi/lo/overflow/done/zero  ALU outputs and status
module alu_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        resp_ovf,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy,
  output logic        alu_en,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_overflow,
  input  logic        alu_done,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT cycle index; WAIT lasts at most TIMEOUT cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic        last_grant;
  logic        sel_vld;
  logic        sel_id;
  logic        hs;
  logic        cap_done;
  logic        cap_to;
  logic [7:0]  wd_cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        id_q;

  // Port selection. On contention, round-robin picks the port that was not
  // granted last; fixed priority always favours port 0.
  always_comb begin
    sel_vld = |req_valid;
    sel_id  = 1'b0;
    case (req_valid)
      2'b10:   sel_id = 1'b1;
      2'b11:   sel_id = RR_EN ? ~last_grant : 1'b0;
      default: sel_id = 1'b0;
    endcase
  end

  assign req_ready = (state_q == IDLE && sel_vld) ? (sel_id ? 2'b10 : 2'b01) : 2'b00;
  assign hs        = |(req_valid & req_ready);

  // Next-state logic. alu_done takes precedence over watchdog expiry in the
  // same cycle, so a late-but-valid result is never discarded.
  always_comb begin
    state_d  = state_q;
    cap_done = 1'b0;
    cap_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          cap_done = 1'b1;
          state_d  = RESP;
        end else if (wd_cnt == WD_LAST) begin
          cap_to  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_en      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_hi     <= '0;
      resp_lo     <= '0;
      resp_ovf    <= 1'b0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_grant  <= 1'b1;
      wd_cnt      <= '0;
    end else begin
      state_q    <= state_d;
      // Both strobes are decoded from the next state so they are clean
      // register outputs aligned with ISSUE and RESP respectively.
      alu_en     <= (state_d == ISSUE);
      resp_valid <= (state_d == RESP);

      // Requester inputs may change right after the handshake; only the
      // latched copy drives the ALU.
      if (hs) begin
        op_q       <= sel_id ? req1_op : req0_op;
        a_q        <= sel_id ? req1_a  : req0_a;
        b_q        <= sel_id ? req1_b  : req0_b;
        id_q       <= sel_id;
        last_grant <= sel_id;
      end

      if (state_q == ISSUE) begin
        wd_cnt <= '0;
      end else if (state_q == WAIT) begin
        wd_cnt <= wd_cnt + 8'd1;
      end

      if (cap_done) begin
        resp_result <= alu_result;
        resp_hi     <= alu_hi;
        resp_lo     <= alu_lo;
        resp_ovf    <= alu_overflow;
        resp_zero   <= alu_zero;
        resp_err    <= 1'b0;
      end else if (cap_to) begin
        resp_result <= '0;
        resp_hi     <= '0;
        resp_lo     <= '0;
        resp_ovf    <= 1'b0;
        resp_zero   <= 1'b0;
        resp_err    <= 1'b1;
      end

      if (state_d == RESP) resp_id <= id_q;
    end
  end

  assign busy        = (state_q != IDLE);
  assign alu_control = op_q;
  assign alu_srcA    = a_q;
  assign alu_srcB    = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int TO = 8;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        hold;
  } alu_out_t;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        zero;
    logic        err;
    logic        chk_res;
    logic        chk_hl;
    int          hs;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req0_op = 4'd0;
  logic [31:0] req0_a = 32'd0;
  logic [31:0] req0_b = 32'd0;
  logic [3:0]  req1_op = 4'd0;
  logic [31:0] req1_a = 32'd0;
  logic [31:0] req1_b = 32'd0;
  logic        suppress = 1'b0;
  logic        stale_inj = 1'b0;
  logic        contend = 1'b0;

  // Index 0: round-robin instance (scoreboarded); index 1: fixed priority.
  logic [1:0]  rdy [2];
  logic        rv [2];
  logic        rid [2];
  logic [31:0] rres [2];
  logic [31:0] rhi [2];
  logic [31:0] rlo [2];
  logic        rovf [2];
  logic        rzero [2];
  logic        rerr [2];
  logic        bsy [2];
  logic        a_en [2];
  logic [3:0]  a_ctl [2];
  logic [31:0] a_sa [2];
  logic [31:0] a_sb [2];
  logic [31:0] a_res [2];
  logic [31:0] a_hi [2];
  logic [31:0] a_lo [2];
  logic        a_ovf [2];
  logic        a_done [2];
  logic        a_zero [2];

  int   rr_grants = 0;
  int   rr_p1 = 0;
  int   fp_grants = 0;
  int   fp_p1 = 0;
  logic exp_port = 1'b0;
  logic prev_en [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.RR_EN(1'b1), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(rv[0]), .resp_id(rid[0]), .resp_result(rres[0]),
    .resp_hi(rhi[0]), .resp_lo(rlo[0]), .resp_ovf(rovf[0]),
    .resp_zero(rzero[0]), .resp_err(rerr[0]), .busy(bsy[0]),
    .alu_en(a_en[0]), .alu_control(a_ctl[0]), .alu_srcA(a_sa[0]), .alu_srcB(a_sb[0]),
    .alu_result(a_res[0]), .alu_hi(a_hi[0]), .alu_lo(a_lo[0]),
    .alu_overflow(a_ovf[0]), .alu_done(a_done[0]), .alu_zero(a_zero[0])
  );

  alu_arbiter #(.RR_EN(1'b0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(rv[1]), .resp_id(rid[1]), .resp_result(rres[1]),
    .resp_hi(rhi[1]), .resp_lo(rlo[1]), .resp_ovf(rovf[1]),
    .resp_zero(rzero[1]), .resp_err(rerr[1]), .busy(bsy[1]),
    .alu_en(a_en[1]), .alu_control(a_ctl[1]), .alu_srcA(a_sa[1]), .alu_srcB(a_sb[1]),
    .alu_result(a_res[1]), .alu_hi(a_hi[1]), .alu_lo(a_lo[1]),
    .alu_overflow(a_ovf[1]), .alu_done(a_done[1]), .alu_zero(a_zero[1])
  );

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL,
  // 8 MULT, 9 DIV, others 0. MULT/DIV leave alu_result held.
  function automatic alu_out_t alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    logic [63:0] p;
    o.res = 32'd0; o.hi = 32'd0; o.lo = 32'd0; o.ovf = 1'b0; o.hold = 1'b0;
    case (op)
      4'd0: begin o.res = a + b; o.ovf = (a[31] == b[31]) && (o.res[31] != a[31]); end
      4'd1: begin o.res = a - b; o.ovf = (a[31] != b[31]) && (o.res[31] != a[31]); end
      4'd2: o.res = a & b;
      4'd3: o.res = a | b;
      4'd4: o.res = a ^ b;
      4'd5: o.res = {31'd0, $signed(a) < $signed(b)};
      4'd6: o.res = b << a[4:0];
      4'd7: o.res = b >> a[4:0];
      4'd8: begin
        o.hold = 1'b1;
        p = {32'd0, a} * {32'd0, b};
        o.hi = p[63:32];
        o.lo = p[31:0];
      end
      4'd9: begin
        o.hold = 1'b1;
        if (b == 32'd0) o.ovf = 1'b1;
        else begin o.lo = a / b; o.hi = a % b; end
      end
      default: o.res = 32'd0;
    endcase
    return o;
  endfunction

  // Behavioural ALUs: done one cycle after enable unless suppressed;
  // stale_inj forces a spurious done with junk data.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        a_res[k] <= 32'd0; a_hi[k] <= 32'd0; a_lo[k] <= 32'd0;
        a_ovf[k] <= 1'b0; a_done[k] <= 1'b0; a_zero[k] <= 1'b0;
      end else if (a_en[k] && !suppress) begin
        alu_out_t o;
        o = alu_ref(a_ctl[k], a_sa[k], a_sb[k]);
        if (!o.hold) a_res[k] <= o.res;
        if (o.hold) begin a_hi[k] <= o.hi; a_lo[k] <= o.lo; end
        a_ovf[k]  <= o.ovf;
        a_zero[k] <= o.hold ? (a_res[k] == 32'd0) : (o.res == 32'd0);
        a_done[k] <= 1'b1;
      end else if (stale_inj) begin
        a_res[k]  <= 32'hDEAD_BEEF;
        a_done[k] <= 1'b1;
      end else begin
        a_done[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p);
    exp_t e;
    alu_out_t o;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    op = (p == 1) ? req1_op : req0_op;
    a  = (p == 1) ? req1_a  : req0_a;
    b  = (p == 1) ? req1_b  : req0_b;
    o  = alu_ref(op, a, b);
    e.id = (p == 1);
    e.hs = cyc;
    if (suppress) begin
      e.err = 1'b1; e.res = 32'd0; e.hi = 32'd0; e.lo = 32'd0; e.ovf = 1'b0; e.zero = 1'b0;
      e.chk_res = 1'b1; e.chk_hl = 1'b1; e.lat = TO + 2;
    end else begin
      e.err = 1'b0; e.res = o.res; e.hi = o.hi; e.lo = o.lo; e.ovf = o.ovf;
      e.zero = (o.res == 32'd0); e.chk_res = !o.hold; e.chk_hl = o.hold; e.lat = 3;
    end
    sb.push_back(e);
  endtask

  // Monitor runs 2 time units after each falling edge, after stimulus settles.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && rdy[0][p]) begin
          push(p);
          if (contend) begin
            check("rr_order", 64'(p), 64'(exp_port));
            exp_port = ~exp_port;
            rr_grants++;
            if (p == 1) rr_p1++;
          end
        end
        if (req_valid[p] && rdy[1][p] && contend) begin
          fp_grants++;
          if (p == 1) fp_p1++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        check("en_back_to_back", 64'(a_en[k] && prev_en[k]), 64'd0);
        check("ready_while_busy", 64'((|rdy[k]) && bsy[k]), 64'd0);
        check("ready_onehot", 64'(rdy[k] == 2'b11), 64'd0);
        prev_en[k] = a_en[k];
      end
      check("fp_p1_ready_vs_p0", 64'(req_valid[0] && rdy[1][1]), 64'd0);
      if (rv[0]) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", 64'(rid[0]), 64'(e.id));
          check("resp_err", 64'(rerr[0]), 64'(e.err));
          check("resp_ovf", 64'(rovf[0]), 64'(e.ovf));
          check("resp_latency", 64'(cyc - e.hs), 64'(e.lat));
          if (e.chk_res) begin
            check("resp_result", 64'(rres[0]), 64'(e.res));
            check("resp_zero", 64'(rzero[0]), 64'(e.zero));
          end
          if (e.chk_hl) begin
            check("resp_hi", 64'(rhi[0]), 64'(e.hi));
            check("resp_lo", 64'(rlo[0]), 64'(e.lo));
          end
        end
      end
    end else begin
      prev_en[0] = 1'b0;
      prev_en[1] = 1'b0;
    end
  end

  task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    if (p == 1) begin req1_op = op; req1_a = a; req1_b = b; req_valid = 2'b10; end
    else begin req0_op = op; req0_a = a; req0_b = b; req_valid = 2'b01; end
    for (int n = 0; n < 30; n++) begin
      #1;
      if (rdy[0][p]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("issue_accept", 64'(got), 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic wait_resp(input int budget);
    logic got;
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (rv[0]) begin got = 1'b1; break; end
    end
    check("resp_arrives", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(bsy[0]), 64'd0);
    check("rst_resp_valid", 64'(rv[0]), 64'd0);
    check("rst_alu_en", 64'(a_en[0]), 64'd0);
    check("rst_resp_result", 64'(rres[0]), 64'd0);
    check("rst_resp_err", 64'(rerr[0]), 64'd0);
    check("rst_alu_control", 64'(a_ctl[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Port 0 ADD 5+7 with explicit cycle-by-cycle timing.
    req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    #1;
    check("add_ready_N", 64'(rdy[0]), 64'd1);
    @(negedge clk);
    req_valid = 2'b00; req0_a = 32'hFFFF_FFFF;
    #1;
    check("add_alu_en_N1", 64'(a_en[0]), 64'd1);
    check("add_srcA", 64'(a_sa[0]), 64'd5);
    check("add_srcB", 64'(a_sb[0]), 64'd7);
    check("add_busy", 64'(bsy[0]), 64'd1);
    @(negedge clk);
    #1;
    check("add_alu_en_N2", 64'(a_en[0]), 64'd0);
    check("add_srcA_held", 64'(a_sa[0]), 64'd5);
    @(negedge clk);
    #1;
    check("add_resp_valid_N3", 64'(rv[0]), 64'd1);
    check("add_result", 64'(rres[0]), 64'd12);
    @(negedge clk);
    #1;
    check("add_resp_drop", 64'(rv[0]), 64'd0);
    check("add_result_persist", 64'(rres[0]), 64'd12);
    check("add_ready_N4", 64'(rdy[0]), 64'd0);

    // Port 1 MULT then DIV by zero.
    issue(1, 4'd8, 32'h0001_0000, 32'h0001_0000);
    wait_resp(12);
    check("mult_hi", 64'(rhi[0]), 64'd1);
    check("mult_lo", 64'(rlo[0]), 64'd0);
    issue(1, 4'd9, 32'd7, 32'd0);
    wait_resp(12);
    check("div0_ovf", 64'(rovf[0]), 64'd1);
    check("div0_err", 64'(rerr[0]), 64'd0);
    check("div0_hi", 64'(rhi[0]), 64'd0);

    // Contention: port 0 SUB 9-9, port 1 OR 0xF0|0x0F, both always valid.
    @(negedge clk);
    req0_op = 4'd1; req0_a = 32'd9;    req0_b = 32'd9;
    req1_op = 4'd3; req1_a = 32'hF0;   req1_b = 32'h0F;
    exp_port = 1'b0;
    contend = 1'b1;
    req_valid = 2'b11;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rr_grants >= 8) break;
    end
    req_valid = 2'b00;
    contend = 1'b0;
    repeat (12) @(negedge clk);
    check("rr_grant_count", 64'(rr_grants), 64'd8);
    check("rr_p1_grants", 64'(rr_p1), 64'd4);
    check("fp_any_grant", 64'(fp_grants > 0), 64'd1);
    check("fp_p1_grants", 64'(fp_p1), 64'd0);

    // Watchdog: no alu_done, then a normal request.
    suppress = 1'b1;
    issue(0, 4'd0, 32'd1, 32'd2);
    wait_resp(20);
    check("to_err", 64'(rerr[0]), 64'd1);
    check("to_result", 64'(rres[0]), 64'd0);
    suppress = 1'b0;
    @(negedge clk);
    issue(0, 4'd4, 32'hA5, 32'h5A);
    wait_resp(12);
    check("after_to_result", 64'(rres[0]), 64'hFF);
    check("after_to_err", 64'(rerr[0]), 64'd0);

    // Reset during WAIT, then a stale alu_done.
    @(negedge clk);
    suppress = 1'b1;
    issue(0, 4'd0, 32'd3, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    suppress = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stale_inj = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bsy[0]), 64'd0);
    check("mid_rst_resp_valid", 64'(rv[0]), 64'd0);
    check("mid_rst_err", 64'(rerr[0]), 64'd0);
    @(negedge clk);
    stale_inj = 1'b0;
    #1;
    check("stale_done_seen", 64'(a_done[0]), 64'd1);
    check("stale_busy", 64'(bsy[0]), 64'd0);
    @(negedge clk);
    #1;
    check("stale_no_resp", 64'(rv[0]), 64'd0);
    req0_op = 4'd0; req0_a = 32'd100; req0_b = 32'd23;
    req1_op = 4'd1; req1_a = 32'd1;   req1_b = 32'd1;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_tie_rr", 64'(rdy[0]), 64'd1);
    check("rst_tie_fp", 64'(rdy[1]), 64'd1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_resp(12);
    check("post_rst_result", 64'(rres[0]), 64'd123);
    check("post_rst_id", 64'(rid[0]), 64'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Sequencer and two-port arbiter for the shared single-cycle ALU (4-bit alu_control, 32-bit operands, hi/lo, overflow, alu_done/alu_zero).
- Accepts operation requests from two requesters, e.g. port 0 = execute stage and port 1 = debug/DMA engine.
- Issues each request to the ALU as a single one-cycle enable pulse and waits for alu_done.
- Returns the captured results on a shared, ID-tagged response bus.
- Enforces one outstanding ALU operation at a time and recovers from a missing alu_done via a watchdog.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration on contention; 0 = fixed priority, port 0 wins.
- TIMEOUT, 8: maximum cycles spent in WAIT before an error response; legal range 2..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; at most one bit high.
- req0_op, req1_op  in  4  ALU opcode (0000 ADD … 1001 DIV), forwarded unchanged.
- req0_a, req1_a  in  32  operand A (shamt for SLL/SRL).
- req0_b, req1_b  in  32  operand B.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  1  port that owns the response.
- resp_result  out  32  captured alu_result.
- resp_hi, resp_lo  out  32 each  captured hi/lo.
- resp_ovf  out  1  captured overflow (also set on DIV by 0).
- resp_zero  out  1  captured alu_zero.
- resp_err  out  1  watchdog expired; all data fields are 0.
- busy  out  1  high in any state other than IDLE.
- alu_en  out  1  ALU enable.
- alu_control  out  4  latched opcode.
- alu_srcA, alu_srcB  out  32 each  latched operands.
- alu_result, alu_hi, alu_lo  in  32 each  ALU outputs.
- alu_overflow, alu_done, alu_zero  in  1 each  ALU status.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All registered outputs are updated on the clk edge only.
- Reset (synchronous, overrides everything, including mid-operation):
  - state = IDLE; alu_en = 0; resp_valid = 0; resp_* data = 0; resp_err = 0.
  - Latched op/operands = 0; last_grant = 1, so port 0 wins the first tie.
  - The ALU has no reset; a stale alu_done arriving after reset is ignored because it is seen only in IDLE.
- IDLE, port selection:
  - If exactly one req_valid bit is set, select that port.
  - If both are set: with RR_EN=1 select the port != last_grant; with RR_EN=0 select port 0.
  - req_ready[sel] = 1 only while in IDLE (combinational from state and req_valid); it is 0 in every other state.
- IDLE, handshake: req_valid[i] & req_ready[i] in the same cycle.
  - Latch the op, a, b and the port id; set last_grant = id; next state ISSUE.
  - A requester may change or drop its inputs after the handshake; the latched copy is used.
- ISSUE: alu_en = 1 for exactly this cycle; alu_control/srcA/srcB show the latched values. Next state WAIT; watchdog counter cleared to 0.
- WAIT:
  - alu_en = 0; operands held stable.
  - If alu_done = 1: capture alu_result, alu_hi, alu_lo, alu_overflow and alu_zero into the resp_* registers with resp_err = 0; next state RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no alu_done: resp_err = 1, data fields = 0, next state RESP.
  - If alu_done and timeout coincide, alu_done wins.
- RESP: resp_valid = 1 for one cycle; resp_id = latched id; next state IDLE. There is no response backpressure; the requester must sink the response.
- Response data persists after resp_valid drops, until the next RESP.
- The controller never interprets opcodes:
  - For MULT/DIV, resp_result reflects the ALU's held alu_result and only hi/lo are meaningful.
  - Opcodes 1010–1111 yield the ALU default result of 0.
- Timing, with the handshake in cycle N: alu_en high in N+1, alu_done high in N+2, resp_valid high in N+3, and the earliest next handshake in N+4. Peak throughput is one operation per 4 cycles.
- Invariants:
  - alu_en is never high on two consecutive cycles.
  - req_ready is never high while busy = 1.
  - At most one request is outstanding.

Test Plan:
- Port 0 ADD, a=5, b=7, alone -> req_ready[0] in cycle N; alu_en in N+1; resp_valid in N+3 with id=0, result=12, ovf=0, zero=0, err=0.
- Both ports valid continuously, RR_EN=1; port 0 SUB 9-9, port 1 OR 0xF0|0x0F -> grant order 0,1,0,1; responses id0 result=0 zero=1, then id1 result=0xFF; no starvation over 8 operations.
- Same stimulus with RR_EN=0 -> port 0 is granted every time; port 1 is never ready while port 0 remains valid.
- Port 1 MULT 0x10000 × 0x10000, then DIV 7/0 -> MULT response hi=1, lo=0; DIV response ovf=1, hi=0, lo=0, err=0.
- ALU model suppresses alu_done, TIMEOUT=8 -> resp_valid exactly 8 cycles after entering WAIT with err=1 and data 0; the following request completes normally.
- Assert rst in the WAIT cycle, then inject a stale alu_done -> after reset, state IDLE, busy=0, no resp_valid; a new port 0 request completes with correct data and port 0 wins the first tie.
